// File: rtl/terrain_column_buffer.sv
// rtl/terrain_column_buffer.sv - clamped, optionally slew-limited terrain heights in a scrolling column buffer
// Optional feature macro: TERRAIN_SMOOTH_EN (STEP-limited smoothing toward a latched target).
module terrain_column_buffer #(
  parameter int         ADDR_W    = 6,
  parameter logic [9:0] MIN_VALUE = 10'd25,
  parameter logic [9:0] MAX_VALUE = 10'd175,
  parameter logic [9:0] STEP      = 10'd4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              game_en,
  input  logic [9:0]        random_in,
  input  logic [ADDR_W-1:0] rd_col,
  output logic [9:0]        rd_height,
  output logic              col_valid,
  output logic              ready
);

  localparam int NUM_COLS = 1 << ADDR_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [9:0]        cur_q, cur_d;
  logic [9:0]        target_q, target_d;
  logic [9:0]        rd_height_q, rd_height_d;
  logic              col_valid_q, col_valid_d;

  logic [9:0]        ram [NUM_COLS];
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [9:0]        wdata;
  logic [ADDR_W-1:0] rd_addr;

  logic [9:0]        clamp;
  logic [9:0]        target_next;
  logic [9:0]        cur_next;

  always_comb begin
    clamp = random_in;
    if (random_in < MIN_VALUE) begin
      clamp = MIN_VALUE;
    end else if (random_in > MAX_VALUE) begin
      clamp = MAX_VALUE;
    end
  end

`ifdef TERRAIN_SMOOTH_EN
  logic [9:0] diff;
  logic [9:0] step_amt;

  // A new target is only latched once the previous one has been reached.
  always_comb begin
    target_next = (cur_q == target_q) ? clamp : target_q;
    diff        = (target_next >= cur_q) ? (target_next - cur_q) : (cur_q - target_next);
    step_amt    = (diff < STEP) ? diff : STEP;
    cur_next    = (target_next >= cur_q) ? (cur_q + step_amt) : (cur_q - step_amt);
  end
`else
  always_comb begin
    target_next = clamp;
    cur_next    = clamp;
  end
`endif

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    cur_d       = cur_q;
    target_d    = target_q;
    col_valid_d = 1'b0;
    we          = 1'b0;
    waddr       = wr_ptr_q;
    wdata       = cur_next;
    case (state_q)
      ST_INIT: begin
        we         = 1'b1;
        waddr      = fill_cnt_q;
        wdata      = MIN_VALUE;
        fill_cnt_d = fill_cnt_q + 1'b1;
        if (&fill_cnt_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (game_en) begin
          we          = 1'b1;
          cur_d       = cur_next;
          target_d    = target_next;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          col_valid_d = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // wr_ptr points at the oldest column, so screen index 0 maps onto it directly.
  assign rd_addr = wr_ptr_q + rd_col;

  always_comb begin
    rd_height_d = MIN_VALUE;
    if (state_q == ST_RUN) begin
      rd_height_d = ram[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      ram[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_INIT;
      fill_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      cur_q       <= MIN_VALUE;
      target_q    <= MIN_VALUE;
      rd_height_q <= MIN_VALUE;
      col_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      cur_q       <= cur_d;
      target_q    <= target_d;
      rd_height_q <= rd_height_d;
      col_valid_q <= col_valid_d;
    end
  end

  assign rd_height = rd_height_q;
  assign col_valid = col_valid_q;
  assign ready     = (state_q == ST_RUN);

endmodule

// File: tb/tb_terrain_column_buffer.sv
// tb/tb_terrain_column_buffer.sv - randomized self-checking bench for terrain_column_buffer
// Reference model follows TERRAIN_SMOOTH_EN the same way the design build does.
module tb_terrain_column_buffer;

  localparam int NUM = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       game_en = 1'b0;
  logic [9:0] random_in = '0;
  logic [5:0] rd_col = '0;
  logic [9:0] rd_height;
  logic       col_valid;
  logic       ready;

  int checks = 0;
  int errors = 0;

  int model_q[$];
  int m_cur;
  int m_tgt;

  terrain_column_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .game_en   (game_en),
    .random_in (random_in),
    .rd_col    (rd_col),
    .rd_height (rd_height),
    .col_valid (col_valid),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    model_q.delete();
    for (int i = 0; i < NUM; i++) model_q.push_back(25);
    m_cur = 25;
    m_tgt = 25;
  endfunction

  function automatic int model_tick(input int raw);
    int c;
    c = (raw < 25) ? 25 : ((raw > 175) ? 175 : raw);
`ifdef TERRAIN_SMOOTH_EN
    if (m_cur == m_tgt) m_tgt = c;
    if (m_tgt > m_cur) m_cur = (m_tgt - m_cur > 4) ? m_cur + 4 : m_tgt;
    else               m_cur = (m_cur - m_tgt > 4) ? m_cur - 4 : m_tgt;
`else
    m_cur = c;
    m_tgt = c;
`endif
    void'(model_q.pop_front());
    model_q.push_back(m_cur);
    return m_cur;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic tick(input int raw);
    int nv;
    game_en   = 1'b1;
    random_in = 10'(raw);
    @(negedge clk);
    game_en = 1'b0;
    nv = model_tick(raw);
    checks++;
    if (col_valid !== 1'b1) begin
      errors++;
      $display("FAIL tick_col_valid: got %b expected 1 (raw %0d)", col_valid, raw);
    end
  endtask

  task automatic read_col(input int idx, output int v);
    rd_col = 6'(idx);
    @(negedge clk);
    v = int'(rd_height);
  endtask

  task automatic check_all(input string name);
    int v;
    for (int i = 0; i < NUM; i++) begin
      read_col(i, v);
      checks++;
      if (v !== model_q[i]) begin
        errors++;
        $display("FAIL %s col %0d: got %0d expected %0d", name, i, v, model_q[i]);
      end
    end
  endtask

  task automatic check_newest(input string name);
    int v;
    read_col(NUM - 1, v);
    checks++;
    if (v !== model_q[NUM-1]) begin
      errors++;
      $display("FAIL %s newest: got %0d expected %0d", name, v, model_q[NUM-1]);
    end
  endtask

  task automatic fill_after_release(input string name);
    for (int k = 1; k <= NUM; k++) begin
      game_en = (k == 10);
      random_in = 10'd100;
      @(negedge clk);
      checks++;
      if (ready !== (k >= NUM)) begin
        errors++;
        $display("FAIL %s ready cycle %0d: got %b expected %b", name, k, ready, (k >= NUM));
      end
      checks++;
      if (col_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s col_valid cycle %0d: got %b expected 0", name, k, col_valid);
      end
    end
    game_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    fill_after_release("reset_fill");
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #10;
    checks++;
    if (rd_height !== 10'd25) begin
      errors++;
      $display("FAIL reset_rd_height: got %0d expected 25", rd_height);
    end
    checks++;
    if (col_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_col_valid: got %b expected 0", col_valid);
    end
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0", ready);
    end
  endtask

  task automatic test_fill();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    fill_after_release("fill");
    check_all("fill_sweep");
  endtask

  task automatic test_smoothing();
    for (int t = 0; t < 6; t++) begin
      tick(45);
      check_newest("smooth");
    end
  endtask

  task automatic test_clamping();
    for (int t = 0; t < 40; t++) begin
      tick(300);
      check_newest("clamp_high");
    end
    for (int t = 0; t < 40; t++) begin
      tick(3);
      check_newest("clamp_low");
    end
    for (int t = 0; t < 30; t++) begin
      tick(100);
      check_newest("clamp_mid");
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int t = 1; t <= 67; t++) tick(25 + (t % 4));
    check_all("wrap");
  endtask

  task automatic test_same_cycle();
    int prev;
    int raw;
    rd_col = 6'd63;
    raw = int'($urandom_range(0, 1023));
    prev = model_q[NUM-1];
    game_en   = 1'b1;
    random_in = 10'(raw);
    @(negedge clk);
    game_en = 1'b0;
    checks++;
    if (int'(rd_height) !== prev) begin
      errors++;
      $display("FAIL same_cycle_old: got %0d expected %0d", rd_height, prev);
    end
    checks++;
    if (col_valid !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_valid: got %b expected 1", col_valid);
    end
    void'(model_tick(raw));
    @(negedge clk);
    checks++;
    if (int'(rd_height) !== model_q[NUM-1]) begin
      errors++;
      $display("FAIL same_cycle_new: got %0d expected %0d", rd_height, model_q[NUM-1]);
    end
    checks++;
    if (col_valid !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_pulse_len: got %b expected 0", col_valid);
    end
  endtask

  task automatic test_back_to_back();
    int raws[4];
    for (int i = 0; i < 4; i++) raws[i] = int'($urandom_range(0, 1023));
    game_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      random_in = 10'(raws[i]);
      @(negedge clk);
      void'(model_tick(raws[i]));
      checks++;
      if (col_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_valid %0d: got %b expected 1", i, col_valid);
      end
    end
    game_en = 1'b0;
    @(negedge clk);
    checks++;
    if (col_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_valid_end: got %b expected 0", col_valid);
    end
    check_all("b2b");
  endtask

  task automatic test_random();
    int v;
    int idx;
    for (int t = 0; t < 80; t++) begin
      tick(int'($urandom_range(0, 1023)));
      idx = int'($urandom_range(0, NUM - 1));
      read_col(idx, v);
      checks++;
      if (v !== model_q[idx]) begin
        errors++;
        $display("FAIL random col %0d: got %0d expected %0d", idx, v, model_q[idx]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    for (int t = 0; t < 20; t++) tick(int'($urandom_range(0, 1023)));
    rd_col    = 6'd63;
    game_en   = 1'b1;
    random_in = 10'd170;
    @(posedge clk);
    #2 rst = 1'b0;
    game_en = 1'b0;
    #1;
    checks++;
    if (rd_height !== 10'd25 || col_valid !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got h=%0d v=%b r=%b expected h=25 v=0 r=0",
               rd_height, col_valid, ready);
    end
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    fill_after_release("mid_reset_fill");
    check_all("mid_reset_sweep");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_smoothing();
    test_clamping();
    test_wrap();
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
